// File: rtl/ls_moment_accum_if.sv
// Handshake and result bundle for the streaming moment accumulator.
// The producer/consumer side uses master; the accumulator uses slave.
interface ls_moment_accum_if #(
    parameter int XW = 12,
    parameter int CW = 9
);
    logic                 start;
    logic                 abort;
    logic                 in_valid;
    logic                 in_ready;
    logic [XW-1:0]        xi;
    logic [XW-1:0]        yi;
    logic                 busy;
    logic                 out_valid;
    logic [CW-1:0]        s0;
    logic [XW+CW-1:0]     sx;
    logic [2*XW+CW-1:0]   sxx;
    logic [XW+CW-1:0]     sy;
    logic [2*XW+CW-1:0]   sxy;

    modport master (
        output start, abort, in_valid, xi, yi,
        input  in_ready, busy, out_valid, s0, sx, sxx, sy, sxy
    );

    modport slave (
        input  start, abort, in_valid, xi, yi,
        output in_ready, busy, out_valid, s0, sx, sxx, sy, sxy
    );
endinterface

// File: rtl/ls_moment_accum.sv
// Streaming moment accumulator: over one batch of N (x, y) samples it
// builds sum(1), sum(x), sum(x^2), sum(y) and sum(x*y) for the 2x2
// least-squares inverse stage. Accumulator widths are sized so that a full
// batch of maximum-valued samples cannot wrap, so no saturation exists.
// sx/sy keep the input fraction; sxx/sxy carry twice the input fraction.
module ls_moment_accum #(
    parameter int N  = 256,
    parameter int XW = 12,
    parameter int CW = $clog2(N+1)
) (
    input  logic              clk,
    input  logic              rst_n,
    ls_moment_accum_if.slave  bus
);
    localparam int LW = XW + CW;
    localparam int QW = 2*XW + CW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_busy;
    logic             r_out_valid;
    logic [CW-1:0]    r_s0;
    logic [LW-1:0]    r_sx;
    logic [QW-1:0]    r_sxx;
    logic [LW-1:0]    r_sy;
    logic [QW-1:0]    r_sxy;

    logic             w_take;
    logic             w_last;
    logic [2*XW-1:0]  w_xx;
    logic [2*XW-1:0]  w_xy;

    // A sample is consumed only while ready; r_in_ready is high exactly in ACC.
    assign w_take = bus.in_valid && r_in_ready;
    // The sample counter doubles as s0, so N-1 means this is the final sample.
    assign w_last = (r_s0 == CW'(N-1));
    // Full-width unsigned products.
    assign w_xx   = {{XW{1'b0}}, bus.xi} * {{XW{1'b0}}, bus.xi};
    assign w_xy   = {{XW{1'b0}}, bus.xi} * {{XW{1'b0}}, bus.yi};

    // Batch control FSM and accumulators; every output is a register here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_s0        <= '0;
            r_sx        <= '0;
            r_sxx       <= '0;
            r_sy        <= '0;
            r_sxy       <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch below
            // reads the pre-edge register values and the default pulse-low of
            // r_out_valid is simply overridden by a later assignment.
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_state    <= ACC;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_s0       <= '0;
                        r_sx       <= '0;
                        r_sxx      <= '0;
                        r_sy       <= '0;
                        r_sxy      <= '0;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ACC: begin
                    if (bus.abort) begin
                        // Abort beats a same-cycle handshake; that sample is dropped.
                        r_state    <= IDLE;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        r_s0       <= '0;
                        r_sx       <= '0;
                        r_sxx      <= '0;
                        r_sy       <= '0;
                        r_sxy      <= '0;
                    end else if (w_take) begin
                        r_s0  <= r_s0 + CW'(1);
                        r_sx  <= r_sx + LW'(bus.xi);
                        r_sxx <= r_sxx + QW'(w_xx);
                        r_sy  <= r_sy + LW'(bus.yi);
                        r_sxy <= r_sxy + QW'(w_xy);
                        if (w_last) begin
                            r_state     <= DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.busy      = r_busy;
    assign bus.out_valid = r_out_valid;
    assign bus.s0        = r_s0;
    assign bus.sx        = r_sx;
    assign bus.sxx       = r_sxx;
    assign bus.sy        = r_sy;
    assign bus.sxy       = r_sxy;

endmodule

// File: tb/tb_ls_moment_accum.sv
// Bench for ls_moment_accum: a small N=4 instance for protocol corners and a
// default N=256 instance for the full-scale no-wrap case. Drivers push the
// expected batch result (sums plus start-to-out_valid latency) into a queue;
// per-instance monitors pop and compare whenever out_valid is seen.
module tb_ls_moment_accum;
    localparam int XW  = 12;
    localparam int NA  = 4;
    localparam int NB  = 256;
    localparam int CWA = $clog2(NA+1);
    localparam int CWB = $clog2(NB+1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ls_moment_accum_if #(.XW(XW), .CW(CWA)) ba ();
    ls_moment_accum_if #(.XW(XW), .CW(CWB)) bb ();

    ls_moment_accum #(.N(NA), .XW(XW)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ba));
    ls_moment_accum #(.N(NB), .XW(XW)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bb));

    typedef struct {
        longint s0;
        longint sx;
        longint sxx;
        longint sy;
        longint sxy;
        int     lat;
        int     st;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t last_a;
    exp_t last_b;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   seen_a = 0, seen_b = 0, pushed_a = 0, pushed_b = 0;

    logic [XW-1:0] xs[$];
    logic [XW-1:0] ys[$];
    int            gaps[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain sums over the loaded samples; latency is N+1 plus stalls.
    function automatic exp_t model(input int n, input int st);
        exp_t e;
        e.s0 = 0; e.sx = 0; e.sxx = 0; e.sy = 0; e.sxy = 0;
        for (int i = 0; i < n; i++) begin
            e.s0  += 1;
            e.sx  += longint'(xs[i]);
            e.sxx += longint'(xs[i]) * longint'(xs[i]);
            e.sy  += longint'(ys[i]);
            e.sxy += longint'(xs[i]) * longint'(ys[i]);
        end
        e.lat = n + 1;
        for (int i = 0; i < n; i++) e.lat += gaps[i];
        e.st = st;
        return e;
    endfunction

    task automatic cmp_out(input string tag, input exp_t e, input logic [63:0] s0,
                           input logic [63:0] sx, input logic [63:0] sxx,
                           input logic [63:0] sy, input logic [63:0] sxy);
        check({tag, "_s0"},  s0,  64'(e.s0));
        check({tag, "_sx"},  sx,  64'(e.sx));
        check({tag, "_sxx"}, sxx, 64'(e.sxx));
        check({tag, "_sy"},  sy,  64'(e.sy));
        check({tag, "_sxy"}, sxy, 64'(e.sxy));
    endtask

    // xv/yv < 0 selects random data; gaps are stall cycles before each sample.
    task automatic load(input int n, input int glo, input int ghi, input int xv, input int yv);
        xs.delete(); ys.delete(); gaps.delete();
        for (int i = 0; i < n; i++) begin
            xs.push_back(xv < 0 ? XW'($urandom) : XW'(xv));
            ys.push_back(yv < 0 ? XW'($urandom) : XW'(yv));
            gaps.push_back(int'($urandom_range(ghi, glo)));
        end
    endtask

    // Scoreboard monitor, N=4 instance.
    always @(negedge clk) begin
        if (rst_n && ba.out_valid) begin
            exp_t e;
            check("a_out_valid_expected", 64'(qa.size() != 0), 64'd1);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                cmp_out("a_result", e, 64'(ba.s0), 64'(ba.sx), 64'(ba.sxx), 64'(ba.sy), 64'(ba.sxy));
                check("a_latency", 64'(cyc - e.st), 64'(e.lat));
                last_a = e;
            end
            seen_a++;
        end
    end

    // Scoreboard monitor, N=256 instance.
    always @(negedge clk) begin
        if (rst_n && bb.out_valid) begin
            exp_t e;
            check("b_out_valid_expected", 64'(qb.size() != 0), 64'd1);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                cmp_out("b_result", e, 64'(bb.s0), 64'(bb.sx), 64'(bb.sxx), 64'(bb.sy), 64'(bb.sxy));
                check("b_latency", 64'(cyc - e.st), 64'(e.lat));
                last_b = e;
            end
            seen_b++;
        end
    end

    task automatic wait_a();
        int budget = 400;
        while (seen_a < pushed_a && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        check("a_done_within_budget", 64'(seen_a >= pushed_a), 64'd1);
    endtask

    task automatic wait_b();
        int budget = 2000;
        while (seen_b < pushed_b && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        check("b_done_within_budget", 64'(seen_b >= pushed_b), 64'd1);
    endtask

    // After a batch: results hold through idle traffic, stray in_valid and abort.
    task automatic hold_a();
        repeat (3) begin
            ba.in_valid = 1'b1; ba.abort = 1'b1;
            ba.xi = XW'($urandom); ba.yi = XW'($urandom);
            @(posedge clk); #1;
        end
        ba.in_valid = 1'b0; ba.abort = 1'b0;
        cmp_out("a_hold", last_a, 64'(ba.s0), 64'(ba.sx), 64'(ba.sxx), 64'(ba.sy), 64'(ba.sxy));
        check("a_hold_busy", 64'(ba.busy), 64'd0);
        check("a_hold_in_ready", 64'(ba.in_ready), 64'd0);
    endtask

    // Drives one N=4 batch from the loaded samples, starting in this cycle.
    task automatic batch_a(input bit start_mid, input bit chain);
        exp_t e;
        ba.start = 1'b1;
        e = model(NA, cyc);
        qa.push_back(e);
        pushed_a++;
        @(posedge clk); #1;
        ba.start = 1'b0;
        check("a_in_ready_in_acc", 64'(ba.in_ready), 64'd1);
        check("a_busy_in_acc", 64'(ba.busy), 64'd1);
        for (int i = 0; i < NA; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                ba.in_valid = 1'b0;
                ba.xi = XW'($urandom); ba.yi = XW'($urandom);
                @(posedge clk); #1;
            end
            ba.in_valid = 1'b1; ba.xi = xs[i]; ba.yi = ys[i];
            if (start_mid && i == 1) ba.start = 1'b1;
            @(posedge clk); #1;
            ba.start = 1'b0; ba.in_valid = 1'b0;
        end
        if (!chain) begin
            wait_a();
            hold_a();
        end
    endtask

    task automatic batch_b();
        exp_t e;
        bb.start = 1'b1;
        e = model(NB, cyc);
        qb.push_back(e);
        pushed_b++;
        @(posedge clk); #1;
        bb.start = 1'b0;
        for (int i = 0; i < NB; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                bb.in_valid = 1'b0;
                @(posedge clk); #1;
            end
            bb.in_valid = 1'b1; bb.xi = xs[i]; bb.yi = ys[i];
            @(posedge clk); #1;
            bb.in_valid = 1'b0;
        end
        wait_b();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        ba.start = 0; ba.abort = 0; ba.in_valid = 0; ba.xi = 0; ba.yi = 0;
        bb.start = 0; bb.abort = 0; bb.in_valid = 0; bb.xi = 0; bb.yi = 0;

        // Reset state.
        #2;
        check("rst_a_s0", 64'(ba.s0), 64'd0);
        check("rst_a_sxy", 64'(ba.sxy), 64'd0);
        check("rst_a_flags", 64'({ba.in_ready, ba.busy, ba.out_valid}), 64'd0);
        check("rst_b_sxx", 64'(bb.sxx), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Continuous stream, xi=16, yi=32: 4/64/1024/128/2048, latency 5.
        load(NA, 0, 0, 16, 32);
        batch_a(1'b0, 1'b0);
        check("a_spec_sxx_16", 64'(ba.sxx), 64'd1024);
        check("a_spec_sxy_16", 64'(ba.sxy), 64'd2048);

        // Stalled stream, one gap before each sample: 4/10/30/26/70, latency 9.
        load(NA, 1, 1, 0, 0);
        xs = '{12'd1, 12'd2, 12'd3, 12'd4};
        ys = '{12'd5, 12'd6, 12'd7, 12'd8};
        batch_a(1'b0, 1'b0);
        check("a_spec_sxy_toggle", 64'(ba.sxy), 64'd70);

        // Abort together with the third handshake.
        ba.start = 1'b1;
        @(posedge clk); #1;
        ba.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ba.in_valid = 1'b1; ba.xi = XW'($urandom); ba.yi = XW'($urandom);
            if (i == 2) ba.abort = 1'b1;
            @(posedge clk); #1;
        end
        ba.in_valid = 1'b0; ba.abort = 1'b0;
        cmp_out("a_abort", '{0, 0, 0, 0, 0, 0, 0}, 64'(ba.s0), 64'(ba.sx), 64'(ba.sxx), 64'(ba.sy), 64'(ba.sxy));
        check("a_abort_flags", 64'({ba.in_ready, ba.busy, ba.out_valid}), 64'd0);
        repeat (6) begin @(posedge clk); #1; end
        load(NA, 0, 0, 1, 1);
        batch_a(1'b0, 1'b0);

        // Start pulsed mid-batch is ignored; start in DONE chains with no gap.
        load(NA, 0, 1, -1, -1);
        batch_a(1'b1, 1'b1);
        load(NA, 0, 0, -1, -1);
        batch_a(1'b0, 1'b0);

        // Randomised batches with random stalls, starts and chaining.
        for (int k = 0; k < 8; k++) begin
            load(NA, 0, 2, -1, -1);
            batch_a(1'($urandom), (k < 7) ? 1'($urandom) : 1'b0);
        end

        // Asynchronous reset in the middle of a batch.
        ba.start = 1'b1;
        @(posedge clk); #1;
        ba.start = 1'b0;
        repeat (2) begin
            ba.in_valid = 1'b1; ba.xi = 12'hfff; ba.yi = 12'hfff;
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        cmp_out("a_midreset", '{0, 0, 0, 0, 0, 0, 0}, 64'(ba.s0), 64'(ba.sx), 64'(ba.sxx), 64'(ba.sy), 64'(ba.sxy));
        check("a_midreset_flags", 64'({ba.in_ready, ba.busy, ba.out_valid}), 64'd0);
        ba.in_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        load(NA, 0, 1, -1, -1);
        batch_a(1'b0, 1'b0);

        // Full-scale N=256 batch: no wrap at the maximum sample value.
        load(NB, 0, 0, 4095, 4095);
        batch_b();
        check("b_spec_s0", 64'(bb.s0), 64'd256);
        check("b_spec_sx", 64'(bb.sx), 64'd1048320);
        check("b_spec_sxx", 64'(bb.sxx), 64'd4292870400);
        check("b_spec_sxy", 64'(bb.sxy), 64'd4292870400);

        // Random N=256 batch with stalls.
        load(NB, 0, 1, -1, -1);
        batch_b();

        repeat (4) begin @(posedge clk); #1; end
        check("a_queue_drained", 64'(qa.size()), 64'd0);
        check("b_queue_drained", 64'(qb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ls_moment_accum.md
# ls_moment_accum

Parametrised streaming moment accumulator for the option-pricing least-squares regression path. It replaces the separate fixed-N X^T X and X^T Y accumulators with a single engine. Over one batch of N (x, y) samples it produces Σ1, Σx, Σx², Σy and Σxy. Samples arrive through a valid/ready handshake, so the upstream path may stall. Results feed the 2×2 matrix-inverse stage unchanged.

## Interface
- N, 256: samples per batch; N ≥ 1.
- XW, 12: width of xi/yi, unsigned fixed point (default Q8.4).
- CW, $clog2(N+1): width of the sample counter and of s0.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a batch; honoured only in IDLE or DONE.
- abort  in  1  cancel the batch in progress; honoured only in ACC.
- in_valid  in  1  xi/yi valid.
- in_ready  out  1  high exactly while in ACC.
- xi  in  XW  sample x.
- yi  in  XW  sample y.
- busy  out  1  high in ACC and DONE.
- out_valid  out  1  one-cycle pulse; results valid.
- s0  out  CW  Σ1 (accepted-sample count).
- sx  out  XW+CW  Σx.
- sxx  out  2XW+CW  Σx².
- sy  out  XW+CW  Σy.
- sxy  out  2XW+CW  Σx·y.

## Operation
- FSM states: IDLE, ACC, DONE. Reset puts the FSM in IDLE.
- Reset values: all accumulators, s0..sxy, out_valid, in_ready and busy are 0.
- IDLE + start:
  - all five accumulators clear to 0; counter clears to 0;
  - next state ACC.
- ACC, handshake (in_valid && in_ready, abort low):
  - s0 += 1; sx += xi; sxx += xi·xi; sy += yi; sxy += xi·yi.
  - All products are full-width unsigned.
- ACC, Nth accepted sample: state → DONE at the same edge.
- ACC, abort:
  - abort wins over a same-cycle handshake; that sample is discarded;
  - accumulators clear to 0; state → IDLE; no out_valid.
- DONE:
  - out_valid = 1 for one cycle; state → IDLE;
  - start in DONE: accumulators clear and state → ACC (back-to-back batches).
- start outside IDLE/DONE is ignored. abort outside ACC is ignored.
- xi/yi are ignored whenever in_ready = 0.
- Outputs come straight from the accumulator registers. After out_valid they hold until the next start, abort or reset.
- Overflow is impossible by construction: N·(2^XW−1)² < 2^(2XW+CW). No saturation logic.
- Fractional scaling (default Q8.4 inputs):
  - sx/sy keep the input fraction (4 bits);
  - sxx/sxy carry double the input fraction (8 bits);
  - s0 is an integer.

## Timing
- start sampled high at edge t → in_ready high from t+1.
- With in_valid held high, samples are accepted at edges t+1 … t+N.
- out_valid is high in the cycle after edge t+N, i.e. N+1 cycles after start; it is registered.
- Each stall cycle (in_valid = 0 in ACC) adds exactly one cycle. Nothing else changes.
- No idle cycle between the last sample and DONE.
- Asynchronous reset mid-batch: all state and outputs go to 0 immediately; the FSM returns to IDLE.

## Test plan
- Reset: assert rst_n = 0 mid-ACC → every output reads 0 without waiting for a clock edge; in_ready = 0; a later start works normally.
- N=4, continuous stream, xi=16, yi=32 → s0=4, sx=64, sxx=1024, sy=128, sxy=2048; out_valid one cycle, exactly 5 cycles after start.
- N=4, in_valid toggling 1,0,1,0…, xi=1,2,3,4, yi=5,6,7,8 → s0=4, sx=10, sxx=30, sy=26, sxy=70; out_valid 9 cycles after start.
- N=4, abort asserted together with the 3rd handshake → IDLE next cycle, outputs 0, no out_valid. Restart with xi=yi=1 → s0=4, sx=4, sxx=4, sy=4, sxy=4.
- Defaults (N=256), xi=yi=4095 every cycle → s0=256, sx=sy=1048320, sxx=sxy=4292870400; no wrap.
- start pulsed mid-ACC → ignored, count continues. start in the DONE cycle → second batch begins with no gap, and first-batch results are visible during the DONE cycle.
